// File: rtl/cplt_sync_pkg.sv
// Shared types and default constants for the completion-to-synchronous bridge.
// The optional RTZ timeout is enabled with the CPLT_SYNC_TIMEOUT_EN macro.
package cplt_sync_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        RTZ   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES:0] chain;

    assign chain[0] = d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic q_reg;

        always_ff @(posedge clk) begin
            if (!rst) begin
                q_reg <= RST_VAL;
            end else begin
                q_reg <= chain[gi];
            end
        end

        assign chain[gi+1] = q_reg;
    end

    assign q = chain[STAGES];

endmodule

// File: rtl/cplt_sync_bridge.sv
// Bridges a 4-phase completion handshake into a valid/ready stream.
// Optional sticky RTZ timeout flag (err port) enabled by macro CPLT_SYNC_TIMEOUT_EN.
module cplt_sync_bridge
    import cplt_sync_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef CPLT_SYNC_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    logic              req_s;
    state_t            state_reg, state_next;
    logic              valid_reg, valid_next;
    logic              ack_reg, ack_next;
    logic [DATA_W-1:0] data_reg, data_next;

    // Flops reset high so a req_in held across reset looks like an old token.
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= RTZ;
            valid_reg <= 1'b0;
            ack_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            ack_reg   <= ack_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        ack_next   = ack_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (req_s) begin
                    data_next  = data_in;
                    valid_next = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    ack_next   = 1'b1;
                    state_next = RTZ;
                end
            end
            RTZ: begin
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                ack_next   = 1'b0;
                state_next = RTZ;
            end
        endcase
    end

    assign out_valid = valid_reg;
    assign ack_out   = ack_reg;
    assign out_data  = data_reg;

`ifdef CPLT_SYNC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    // Counts cycles spent in RTZ; saturates at the limit, err stays set until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (state_reg != RTZ) begin
            cnt_reg <= '0;
        end else begin
            if (cnt_reg != CNT_W'(TIMEOUT_CYC)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: doc/cplt_sync_bridge.md
CPLT_SYNC_BRIDGE -- requirements
Module: cplt_sync_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of bundled data word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: req synchronizer depth.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: RTZ timeout limit; used only with CPLT_SYNC_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_in  input  1  asynchronous completion (4-phase req) from upstream C-element tree.
REQ-007 SHALL have port data_in  input  DATA_W  bundled data, stable while req_in high.
REQ-008 SHALL have port ack_out  output  1  4-phase acknowledge to async domain.
REQ-009 SHALL have port out_valid  output  1  sync-side valid.
REQ-010 SHALL have port out_ready  input  1  sync-side ready.
REQ-011 SHALL have port out_data  output  DATA_W  captured word.
REQ-012 SHALL have port err  output  1  sticky timeout flag; present only with CPLT_SYNC_TIMEOUT_EN.

Function
REQ-013 SHALL pass req_in through SYNC_STAGES flops to req_s; sole use of req_in.
REQ-014 SHALL implement FSM states IDLE, VALID, RTZ; all outputs registered.
REQ-015 IDLE: on req_s=1, capture data_in into out_data, set out_valid=1, go VALID; ack_out stays 0.
REQ-016 VALID: hold out_valid=1 and out_data constant until out_valid&out_ready; that cycle clear out_valid, set ack_out=1, go RTZ.
REQ-017 RTZ: hold ack_out=1 until req_s=0; then clear ack_out, go IDLE.
REQ-018 Latency req_in rise -> out_valid: SYNC_STAGES+1 cycles; handshake -> ack_out rise: 1 cycle; req_in fall -> ack_out fall: SYNC_STAGES+1 cycles.
REQ-019 out_ready asserted in IDLE or RTZ SHALL be ignored; no word accepted twice.
REQ-020 Exactly one out_valid/out_ready transfer per req_in rise/fall cycle; req_in re-rise in RTZ before req_s falls is a protocol violation, no second token generated.
REQ-021 out_ready low indefinitely SHALL stall in VALID with ack_out=0 (backpressure to async domain).

Reset
REQ-022 In reset: out_valid=0, ack_out=0, out_data=0, err=0, FSM=RTZ, synchronizer flops=1.
REQ-023 After reset SHALL accept no token until req_s observed 0; a req_in held high across reset SHALL NOT produce a word.
REQ-024 Reset mid-handshake SHALL drop any held word and drive ack_out=0 in the reset cycle.

Configuration
REQ-025 Macro CPLT_SYNC_TIMEOUT_EN defined: counter of $clog2(TIMEOUT_CYC+1) bits counts RTZ cycles, clears on entry; reaching TIMEOUT_CYC sets err, sticky until reset; FSM behaviour unchanged.
REQ-026 Macro undefined: no counter, no err port.

Structure
REQ-027 Package cplt_sync_pkg SHALL hold FSM state typedef (IDLE, VALID, RTZ) and default constants for DATA_W, SYNC_STAGES, TIMEOUT_CYC.
REQ-028 Synchronizer SHALL be sub-module sync_ff (parameters STAGES, RST_VAL) instantiated once.

Verification
REQ-029 Reset, req_in=0, data_in=8'hA5, req_in rise, out_ready=1 -> out_valid at cycle 3, out_data=8'hA5, ack_out rises cycle 4; req_in fall -> ack_out 0 three cycles later.
REQ-030 out_ready=0 for 20 cycles after out_valid -> out_valid, out_data stable, ack_out=0 throughout; out_ready=1 -> single transfer.
REQ-031 req_in=1 held across reset release -> no out_valid until req_in low then high again with 8'h3C -> one word 8'h3C.
REQ-032 Reset asserted in VALID -> next cycle out_valid=0, ack_out=0, out_data=0.
REQ-033 100 back-to-back random tokens, random out_ready -> scoreboard exact order, no duplicates/drops.
REQ-034 With CPLT_SYNC_TIMEOUT_EN, TIMEOUT_CYC=16, req_in held high after ack -> err=1 after 16 RTZ cycles, stays 1 after req_in falls, clears only on reset.
